// File: rtl/photo_interrupt_ctrl_if.sv
// rtl/photo_interrupt_ctrl_if.sv - host/sensor signal bundle for photo_interrupt_ctrl
//
// Groups the sensor input, host controls and status outputs of the
// photo-interrupter controller. clk and rst are kept as plain ports.
//
// Signals:
//   enable        host -> ctrl  1 = detection active
//   sensor        pin  -> ctrl  raw asynchronous sensor, 1 = beam blocked
//   irq_ack       host -> ctrl  acknowledge of irq
//   cnt_clr       host -> ctrl  synchronous clear of count and overflow
//   led           ctrl -> host  status LED
//   beam_blocked  ctrl -> host  debounced sensor level
//   count         ctrl -> host  committed block events (saturating)
//   irq           ctrl -> host  level interrupt, held until acknowledged
//   overflow      ctrl -> host  sticky counter saturation flag
interface photo_interrupt_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             sensor;
  logic             irq_ack;
  logic             cnt_clr;
  logic             led;
  logic             beam_blocked;
  logic [CNT_W-1:0] count;
  logic             irq;
  logic             overflow;

  modport master (
    output enable, sensor, irq_ack, cnt_clr,
    input  led, beam_blocked, count, irq, overflow
  );

  modport slave (
    input  enable, sensor, irq_ack, cnt_clr,
    output led, beam_blocked, count, irq, overflow
  );
endinterface

// File: rtl/photo_interrupt_ctrl.sv
// rtl/photo_interrupt_ctrl.sv - photo-interrupter debounce, event counter, irq and LED driver
//
// Synchronizes and debounces the raw sensor line, counts committed beam-block
// events in a saturating counter with a sticky overflow flag, raises a level
// interrupt held until acknowledged, and drives a status LED.
//
// Build option macro: PHOTO_LED_STRETCH_EN
//   defined   - LED is held high for LED_HOLD_CYCLES after every event
//   undefined - no hold timer, led follows beam_blocked
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   bus  photo_interrupt_ctrl_if.slave
//        in : enable, sensor, irq_ack, cnt_clr
//        out: led, beam_blocked, count, irq, overflow
module photo_interrupt_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int LED_HOLD_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  photo_interrupt_ctrl_if.slave bus
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (DEBOUNCE_CYCLES < 2 || LED_HOLD_CYCLES < 1) begin : g_bad_params
    $error("photo_interrupt_ctrl: need DEBOUNCE_CYCLES >= 2 and LED_HOLD_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    CHK_BLOCK = 2'd1,
    BLOCKED   = 2'd2,
    CHK_CLEAR = 2'd3
  } state_t;

  logic             sync1_q, sync2_q;
  logic             sensor_s;
  state_t           state_q, state_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic             commit;
  logic             beam_q, beam_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;

  assign sensor_s = sync2_q;

  // Debounce FSM: a level change is committed only after DEBOUNCE_CYCLES
  // consecutive identical synchronized samples.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    commit  = 1'b0;
    if (!bus.enable) begin
      state_d = CLEAR;
      db_d    = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (sensor_s) begin
            state_d = CHK_BLOCK;
            db_d    = DB_W'(1);
          end
        end
        CHK_BLOCK: begin
          if (!sensor_s) begin
            state_d = CLEAR;
          end else if (db_q == DB_LAST) begin
            state_d = BLOCKED;
            commit  = 1'b1;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
        BLOCKED: begin
          if (!sensor_s) begin
            state_d = CHK_CLEAR;
            db_d    = DB_W'(1);
          end
        end
        CHK_CLEAR: begin
          // Returning to BLOCKED here is a bounce, not a new event.
          if (sensor_s) begin
            state_d = BLOCKED;
          end else if (db_q == DB_LAST) begin
            state_d = CLEAR;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_comb begin
    beam_d  = (state_d == BLOCKED) || (state_d == CHK_CLEAR);
    count_d = count_q;
    ovf_d   = ovf_q;
    // Clear first so a coincident event lands on a freshly cleared counter.
    if (bus.cnt_clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (commit) begin
      if (count_d == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_d + 1'b1;
      end
    end
    // A new event beats a coincident acknowledge.
    irq_d = irq_q;
    if (commit) begin
      irq_d = 1'b1;
    end else if (bus.irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= CLEAR;
      db_q    <= '0;
      beam_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= bus.sensor;
      sync2_q <= sync1_q;
      state_q <= state_d;
      db_q    <= db_d;
      beam_q  <= beam_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.beam_blocked = beam_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.irq          = irq_q;

`ifdef PHOTO_LED_STRETCH_EN
  localparam int LT_W = $clog2(LED_HOLD_CYCLES + 1);

  logic [LT_W-1:0] led_tmr_q, led_tmr_d;

  // Keeps running while detection is disabled so a pending hold still expires.
  always_comb begin
    led_tmr_d = led_tmr_q;
    if (commit) begin
      led_tmr_d = LT_W'(LED_HOLD_CYCLES);
    end else if (led_tmr_q != '0) begin
      led_tmr_d = led_tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_tmr_q <= '0;
    end else begin
      led_tmr_q <= led_tmr_d;
    end
  end

  assign bus.led = beam_q | (led_tmr_q != '0);
`else
  assign bus.led = beam_q;
`endif

endmodule

// File: tb/tb_photo_interrupt_ctrl.sv
// tb/tb_photo_interrupt_ctrl.sv - scoreboard bench for photo_interrupt_ctrl
module tb_photo_interrupt_ctrl;

  localparam int DC   = 4;
  localparam int CW   = 3;
  localparam int HOLD = 50;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  photo_interrupt_ctrl_if #(.CNT_W(CW)) bus ();

  photo_interrupt_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW),
    .LED_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit beam;
    bit led;
    bit irq;
    bit ovf;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: a level is accepted once DC consecutive synchronized
  // samples disagree with the current accepted level.
  int m_s1, m_s2, m_level, m_run, m_cnt, m_ovf, m_irq, m_timer;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
    m_cnt = 0; m_ovf = 0; m_irq = 0; m_timer = 0;
  endtask

  task automatic model_edge(input logic en, input logic sen, input logic ack, input logic clr);
    int   s;
    bit   ev;
    exp_t e;
    s  = m_s2;
    ev = 1'b0;
    if (!en) begin
      m_level = 0;
      m_run   = 0;
    end else if (s != m_level) begin
      m_run = m_run + 1;
      if (m_run == DC) begin
        m_level = s;
        m_run   = 0;
        ev      = (s == 1);
      end
    end else begin
      m_run = 0;
    end
    if (clr) begin
      m_cnt = 0;
      m_ovf = 0;
    end
    if (ev) begin
      if (m_cnt == CMAX) m_ovf = 1;
      else m_cnt = m_cnt + 1;
    end
    if (ev) m_irq = 1;
    else if (ack) m_irq = 0;
    if (ev) m_timer = HOLD;
    else if (m_timer > 0) m_timer = m_timer - 1;
    m_s2 = m_s1;
    m_s1 = sen ? 1 : 0;
    e.beam = (m_level != 0);
`ifdef PHOTO_LED_STRETCH_EN
    e.led = (m_level != 0) || (m_timer > 0);
`else
    e.led = (m_level != 0);
`endif
    e.irq = (m_irq != 0);
    e.ovf = (m_ovf != 0);
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.beam_blocked !== e.beam || bus.led !== e.led || bus.irq !== e.irq ||
          bus.overflow !== e.ovf || bus.count !== CW'(e.cnt)) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d got beam=%b led=%b irq=%b ovf=%b cnt=%0d expected beam=%b led=%b irq=%b ovf=%b cnt=%0d",
                 cyc, bus.beam_blocked, bus.led, bus.irq, bus.overflow, bus.count,
                 e.beam, e.led, e.irq, e.ovf, e.cnt);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Called at a falling edge; drives inputs, lets one rising edge happen,
  // records the model's expectation and returns at the next falling edge.
  task automatic step(input logic en, input logic sen, input logic ack, input logic clr);
    bus.enable  = en;
    bus.sensor  = sen;
    bus.irq_ack = ack;
    bus.cnt_clr = clr;
    @(posedge clk);
    cyc++;
    model_edge(en, sen, ack, clr);
    @(negedge clk);
  endtask

  task automatic hold(input int n, input logic en, input logic sen);
    for (int i = 0; i < n; i++) step(en, sen, 1'b0, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, " led"},      bus.led, 0);
    check({tag, " beam"},     bus.beam_blocked, 0);
    check({tag, " count"},    bus.count, 0);
    check({tag, " irq"},      bus.irq, 0);
    check({tag, " overflow"}, bus.overflow, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int   len;
    logic lvl;
    bus.enable = 1'b1; bus.sensor = 1'b0; bus.irq_ack = 1'b0; bus.cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset led",      bus.led, 0);
    check("reset beam",     bus.beam_blocked, 0);
    check("reset count",    bus.count, 0);
    check("reset irq",      bus.irq, 0);
    check("reset overflow", bus.overflow, 0);
    rst = 1'b0;

    // Block latency: edges 0..4 quiet, edge 5 commits.
    hold(5, 1'b1, 1'b1);
    check("t1 beam before edge5", bus.beam_blocked, 0);
    check("t1 irq before edge5",  bus.irq, 0);
    check("t1 led before edge5",  bus.led, 0);
    hold(1, 1'b1, 1'b1);
    check("t1 beam at edge5",  bus.beam_blocked, 1);
    check("t1 irq at edge5",   bus.irq, 1);
    check("t1 led at edge5",   bus.led, 1);
    check("t1 count at edge5", bus.count, 1);
    hold(14, 1'b1, 1'b1);
    check("t1 count after hold", bus.count, 1);

    // Acknowledge clears irq.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3 irq after ack", bus.irq, 0);

    // Release latency.
    hold(5, 1'b1, 1'b0);
    check("release beam before edge5", bus.beam_blocked, 1);
    hold(1, 1'b1, 1'b0);
    check("release beam at edge5", bus.beam_blocked, 0);
    hold(2, 1'b1, 1'b0);

    // Event coincident with acknowledge keeps irq set.
    hold(5, 1'b1, 1'b1);
    check("t3 irq before coincident", bus.irq, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3 irq event beats ack", bus.irq, 1);
    check("t3 count coincident",    bus.count, 2);
    hold(4, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3 irq plain ack", bus.irq, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3 ack while idle", bus.irq, 0);
    hold(8, 1'b1, 1'b0);

    // Glitch rejection.
    async_reset_check("rst glitch");
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2 beam glitch high", bus.beam_blocked, 0);
      end
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2 beam glitch low", bus.beam_blocked, 0);
      end
    end
    hold(4, 1'b1, 1'b0);
    check("t2 count", bus.count, 0);
    check("t2 irq",   bus.irq, 0);

    // Saturation, then clear coincident with an event.
    async_reset_check("rst sat");
    for (int i = 0; i < 9; i++) begin
      hold(8, 1'b1, 1'b1);
      hold(8, 1'b1, 1'b0);
    end
    check("t4 count saturated", bus.count, CMAX);
    check("t4 overflow",        bus.overflow, 1);
    hold(5, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t4 count clr+event",    bus.count, 1);
    check("t4 overflow clr+event", bus.overflow, 0);
    hold(3, 1'b1, 1'b1);
    hold(8, 1'b1, 1'b0);

    // LED behaviour after a short block (commit at edge 5, release from edge 10).
    async_reset_check("rst led");
    hold(10, 1'b1, 1'b1);
`ifdef PHOTO_LED_STRETCH_EN
    hold(45, 1'b1, 1'b0);
    check("t5 led last hold cycle", bus.led, 1);
    check("t5 beam during hold",    bus.beam_blocked, 0);
    hold(1, 1'b1, 1'b0);
    check("t5 led hold expired",    bus.led, 0);
`else
    hold(5, 1'b1, 1'b0);
    check("t5 led tracks beam high", bus.led, 1);
    hold(1, 1'b1, 1'b0);
    check("t5 led tracks beam low",  bus.led, 0);
`endif
    hold(5, 1'b1, 1'b0);

    // Disabled detection ignores a long block.
    hold(20, 1'b0, 1'b1);
    check("t6 count while disabled", bus.count, 1);
    check("t6 beam while disabled",  bus.beam_blocked, 0);
    hold(8, 1'b1, 1'b1);
    check("t6 count after enable", bus.count, 2);
    hold(8, 1'b1, 1'b0);

    // Asynchronous reset while debouncing a block.
    hold(3, 1'b1, 1'b1);
    async_reset_check("rst chk_block");
    hold(8, 1'b1, 1'b0);
    check("t6 count after reset", bus.count, 0);
    check("t6 irq after reset",   bus.irq, 0);

    // Randomized runs of sensor level with sporadic control inputs.
    for (int k = 0; k < 200; k++) begin
      len = $urandom_range(1, 12);
      lvl = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        step(1'($urandom_range(0, 15) != 0), lvl,
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 40) == 0));
      end
      if (k == 100) async_reset_check("rst random");
    end

    @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/photo_interrupt_ctrl.md
# photo_interrupt_ctrl

Controller for a slotted photo-interrupter sensor. It synchronizes and debounces the raw `sensor` line and counts debounced beam-block events in a saturating counter. It also raises a level interrupt with an acknowledge handshake and drives a status LED with a minimum on-time. It sits between the sensor pin and the host/status logic, replacing direct sensor-to-LED wiring.

## Interface
- `DEBOUNCE_CYCLES`, 16, consecutive stable synchronized samples required to commit a level change (≥2)
- `CNT_W`, 16, width of the event counter
- `LED_HOLD_CYCLES`, 1000, minimum cycles `led` stays high after a block event (≥1)

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `enable`  in  1  1 = detection active
- `sensor`  in  1  raw, asynchronous sensor input; 1 = beam blocked
- `irq_ack`  in  1  host acknowledge of `irq`
- `cnt_clr`  in  1  synchronous clear of `count` and `overflow`
- `led`  out  1  status LED
- `beam_blocked`  out  1  debounced sensor level
- `count`  out  CNT_W  number of committed block events
- `irq`  out  1  event interrupt, level, held until acknowledged
- `overflow`  out  1  sticky; set when an event arrives with `count` at all-ones

## Operation
- **Synchronizer.** Two-flop synchronizer on `sensor` gives `sensor_s`. All logic uses `sensor_s` only.
- **Debounce FSM** with states CLEAR, CHK_BLOCK, BLOCKED, CHK_CLEAR, and a debounce counter `db`.
  - CLEAR: `sensor_s`=1 → CHK_BLOCK, `db`=1.
  - CHK_BLOCK: `sensor_s`=0 → CLEAR. Otherwise, if `db`==DEBOUNCE_CYCLES-1 → BLOCKED (commit event), else `db`++.
  - BLOCKED: `sensor_s`=0 → CHK_CLEAR, `db`=1.
  - CHK_CLEAR: `sensor_s`=1 → BLOCKED (no new event). Otherwise, if `db`==DEBOUNCE_CYCLES-1 → CLEAR, else `db`++.
- **`beam_blocked`** is 1 in BLOCKED and CHK_CLEAR, 0 otherwise.
- **Event commit** happens on the CHK_BLOCK→BLOCKED transition only:
  - `count`++ if not all-ones; otherwise `count` holds and `overflow`←1.
  - `irq`←1.
  - LED hold timer loaded with LED_HOLD_CYCLES.
- **`enable`=0** forces the FSM to CLEAR and `db` to 0 on the next edge. No events are committed. `count`, `overflow` and `irq` hold their values. The LED timer keeps counting down.
- **`irq` handshake.**
  - `irq_ack`=1 while `irq`=1 clears `irq` on that edge.
  - If an event commits on the same edge as the ack, `irq` stays 1 (the event wins).
  - `irq_ack` while `irq`=0 has no effect.
- **`cnt_clr`** sets `count`←0 and `overflow`←0. If an event commits on the same edge, the result is `count`=1 and `overflow`=0.
- **`led`** = `beam_blocked` OR (LED timer ≠ 0). The timer decrements by 1 per cycle down to 0.

## Timing
- **Reset values:** `led`=0, `beam_blocked`=0, `count`=0, `irq`=0, `overflow`=0, FSM=CLEAR, `db`=0, LED timer=0, synchronizer flops=0.
- **Block latency.** The first edge sampling `sensor`=1 is edge 0. `sensor_s`=1 after edge 1. With `sensor` held high, `beam_blocked`, `count`, `irq` and `led` all update on edge DEBOUNCE_CYCLES+1.
- **Release latency.** Symmetric: `beam_blocked` falls on edge DEBOUNCE_CYCLES+1 after the first low sample.
- **Glitches.** Any `sensor_s` glitch shorter than DEBOUNCE_CYCLES cycles produces no state change.
- All outputs are registered. No combinational path from inputs to outputs, except the `led` OR of two registered terms.
- **Mid-operation reset.** Reset asserted mid-operation returns all state to the reset values immediately, with no event committed.
- **Counter width.** The counter saturates and never wraps. `db` is `$clog2(DEBOUNCE_CYCLES)+1` bits.

## Configuration
- **Macro:** `PHOTO_LED_STRETCH_EN`.
- **Defined:** the LED hold timer is present and the behaviour is as above.
- **Undefined:** no timer is generated, `led` = `beam_blocked`, and LED_HOLD_CYCLES is ignored.
- All other behaviour is identical in both builds.

## Test plan
1. **Reset and basic event.** DEBOUNCE_CYCLES=4. Reset, then hold `sensor`=1 for 20 cycles → `beam_blocked`, `irq` and `led` rise exactly 5 edges after the first high sample, `count`=1.
2. **Glitch rejection.** Pulse `sensor` high for 3 cycles and low for 3 cycles, repeated 5 times → `count`=0, `irq`=0, `beam_blocked`=0 throughout.
3. **Interrupt handshake.**
   - Event, then `irq_ack` pulse → `irq`=0 on the next edge.
   - Event committing on the same edge as `irq_ack` → `irq` stays 1.
4. **Saturation and clear.**
   - CNT_W=3, 9 clean events → `count`=7, `overflow`=1.
   - `cnt_clr` coincident with a 10th event → `count`=1, `overflow`=0.
5. **LED stretch.** `PHOTO_LED_STRETCH_EN` defined, LED_HOLD_CYCLES=50, block for 10 cycles → `led` stays high 50 cycles after the commit edge. With the macro undefined, `led` tracks `beam_blocked`.
6. **Enable and async reset.**
   - `enable`=0 with a long block → no event, `count` unchanged.
   - Async `rst` pulse in CHK_BLOCK → all outputs 0 immediately, no event committed.
